// File: rtl/oled_pkg.sv
// Shared definitions for the 96x64 PmodOLEDrgb pixel path: geometry, RGB565
// colour constants and the streamer state encoding.
package oled_pkg;

    localparam int OLED_WIDTH  = 96;
    localparam int OLED_HEIGHT = 64;
    localparam int OLED_PIXELS = OLED_WIDTH * OLED_HEIGHT;
    localparam int PIX_IDX_W   = 13;
    localparam int COLOR_W     = 16;

    localparam logic [COLOR_W-1:0] RED   = 16'hF800;
    localparam logic [COLOR_W-1:0] BLACK = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT
    } state_t;

endpackage

// File: rtl/spi_word_shifter.sv
// Mode-0 SPI word transmitter: loads one RGB565 word and shifts it MSB-first
// over 32 cycles (two clk25 cycles per bit), with chip select low for the word.
module spi_word_shifter
    import oled_pkg::*;
(
    input  logic               clk25,
    input  logic               rst_n,
    input  logic               load,
    input  logic [COLOR_W-1:0] data,
    output logic               sclk,
    output logic               mosi,
    output logic               cs_n,
    output logic               done
);

    // Only the bits still to be sent are kept; bit 15 goes straight to mosi on load.
    logic [COLOR_W-2:0] sreg_q, sreg_d;
    logic [4:0]         cnt_q,  cnt_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic               cs_n_q, cs_n_d;

    assign done = !cs_n_q && (cnt_q == 5'd31);

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        cs_n_d = cs_n_q;
        if (load) begin
            sreg_d = data[COLOR_W-2:0];
            cnt_d  = 5'd0;
            sclk_d = 1'b0;
            mosi_d = data[COLOR_W-1];
            cs_n_d = 1'b0;
        end else if (!cs_n_q) begin
            cnt_d = cnt_q + 5'd1;
            if (done) begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
            end else if (cnt_q[0]) begin
                sclk_d = 1'b0;
                sreg_d = {sreg_q[COLOR_W-3:0], 1'b0};
                mosi_d = sreg_q[COLOR_W-2];
            end else begin
                sclk_d = 1'b1;
            end
        end
    end

    // NOTE: reset is synchronous and clears the shift register too, so a word cut
    // short by reset leaves nothing behind; state updates use non-blocking assignments.
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            cs_n_q <= 1'b1;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
            cs_n_q <= cs_n_d;
        end
    end

    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign cs_n = cs_n_q;

endmodule

// File: rtl/oled_pixel_streamer.sv
// Scans the OLED frame pixel by pixel, fetches each colour from the registered
// generators and streams it to the display through spi_word_shifter.
module oled_pixel_streamer
    import oled_pkg::*;
#(
    parameter int WIDTH     = OLED_WIDTH,
    parameter int HEIGHT    = OLED_HEIGHT,
    parameter int FETCH_CYC = 2
) (
    input  logic                 clk25,
    input  logic                 rst_n,
    input  logic                 enable,
    output logic [PIX_IDX_W-1:0] pixel_index,
    input  logic [COLOR_W-1:0]   color,
    output logic                 oled_sclk,
    output logic                 oled_mosi,
    output logic                 oled_cs_n,
    output logic                 oled_dc,
    output logic                 frame_begin,
    output logic                 frame_done,
    output logic                 busy
);

    localparam int                   PIXELS     = WIDTH * HEIGHT;
    localparam int                   FCNT_W     = (FETCH_CYC > 1) ? $clog2(FETCH_CYC) : 1;
    localparam logic [FCNT_W-1:0]    FETCH_LAST = FCNT_W'(FETCH_CYC - 1);
    localparam logic [PIX_IDX_W-1:0] PIX_LAST   = PIX_IDX_W'(PIXELS - 1);

    state_t               state_q,       state_d;
    logic [FCNT_W-1:0]    fetch_cnt_q,   fetch_cnt_d;
    logic [PIX_IDX_W-1:0] pix_q,         pix_d;
    logic                 dc_q,          dc_d;
    logic                 frame_begin_q, frame_begin_d;
    logic                 frame_done_q,  frame_done_d;
    logic                 busy_q,        busy_d;

    logic [PIX_IDX_W-1:0] pix_next;
    logic                 load;
    logic                 shift_done;

    always_comb begin
        state_d       = state_q;
        fetch_cnt_d   = fetch_cnt_q;
        pix_d         = pix_q;
        dc_d          = dc_q;
        frame_begin_d = 1'b0;
        frame_done_d  = 1'b0;
        load          = 1'b0;
        pix_next      = (pix_q == PIX_LAST) ? '0 : pix_q + 1'b1;

        case (state_q)
            IDLE: begin
                pix_d = '0;
                if (enable) begin
                    state_d       = FETCH;
                    fetch_cnt_d   = '0;
                    dc_d          = 1'b1;
                    frame_begin_d = 1'b1;
                end
            end
            FETCH: begin
                // The last fetch edge is where the generator's colour is valid.
                if (fetch_cnt_q == FETCH_LAST) begin
                    load        = 1'b1;
                    state_d     = SHIFT;
                    fetch_cnt_d = '0;
                end else begin
                    fetch_cnt_d = fetch_cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                // enable only matters at a word boundary; a word is never cut short.
                if (shift_done) begin
                    frame_done_d = (pix_q == PIX_LAST);
                    if (enable) begin
                        state_d       = FETCH;
                        pix_d         = pix_next;
                        frame_begin_d = (pix_next == '0);
                    end else begin
                        state_d = IDLE;
                        pix_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fetch_cnt_q   <= '0;
            pix_q         <= '0;
            dc_q          <= 1'b0;
            frame_begin_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_cnt_q   <= fetch_cnt_d;
            pix_q         <= pix_d;
            dc_q          <= dc_d;
            frame_begin_q <= frame_begin_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
        end
    end

    spi_word_shifter u_shifter (
        .clk25 (clk25),
        .rst_n (rst_n),
        .load  (load),
        .data  (color),
        .sclk  (oled_sclk),
        .mosi  (oled_mosi),
        .cs_n  (oled_cs_n),
        .done  (shift_done)
    );

    assign pixel_index = pix_q;
    assign oled_dc     = dc_q;
    assign frame_begin = frame_begin_q;
    assign frame_done  = frame_done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Bench for oled_pixel_streamer on a reduced 10x8 frame: a pixel-period model
// predicts every output each cycle and an SPI receiver decodes the words.
module tb_oled_pixel_streamer;

    localparam int W      = 10;
    localparam int H      = 8;
    localparam int PIX    = W * H;
    localparam int FC     = 2;
    localparam int PERIOD = FC + 32;

    logic        clk25 = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [12:0] pixel_index;
    logic [15:0] color = 16'h0;
    logic        oled_sclk, oled_mosi, oled_cs_n, oled_dc;
    logic        frame_begin, frame_done, busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] pal [0:8191];

    oled_pixel_streamer #(.WIDTH(W), .HEIGHT(H), .FETCH_CYC(FC)) dut (
        .clk25       (clk25),
        .rst_n       (rst_n),
        .enable      (enable),
        .pixel_index (pixel_index),
        .color       (color),
        .oled_sclk   (oled_sclk),
        .oled_mosi   (oled_mosi),
        .oled_cs_n   (oled_cs_n),
        .oled_dc     (oled_dc),
        .frame_begin (frame_begin),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #5 clk25 = ~clk25;

    // Colour generator with exactly one registered cycle of latency.
    always @(posedge clk25) color <= pal[pixel_index];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: m_ph is the position inside the 34-cycle pixel period (-1 = idle).
    int          m_ph   = -1;
    logic [12:0] m_idx  = '0;
    logic        m_fb   = 1'b0;
    logic        m_fd   = 1'b0;
    logic        m_dc   = 1'b0;
    logic        m_mosi = 1'b0;
    logic [15:0] m_word = '0;
    logic        rst_s  = 1'b0;
    logic        en_s   = 1'b0;

    logic [15:0] dec_word = '0;
    int          dec_bits = 0;
    int          dec_len  = 0;
    logic        prev_cs  = 1'b1;
    logic        prev_sclk = 1'b0;
    int          n_wrap   = 0;

    always @(negedge clk25) begin
        if (!rst_s) begin
            m_ph = -1; m_idx = '0; m_fb = 1'b0; m_fd = 1'b0; m_dc = 1'b0; m_mosi = 1'b0;
        end else if (m_ph < 0) begin
            m_fd = 1'b0;
            m_fb = en_s;
            if (en_s) begin
                m_ph = 0; m_idx = '0; m_dc = 1'b1;
            end
        end else if (m_ph == PERIOD - 1) begin
            m_fd  = (m_idx == PIX - 1);
            m_idx = (m_idx == PIX - 1) ? 13'd0 : m_idx + 13'd1;
            if (en_s) begin
                m_ph = 0; m_fb = (m_idx == 0);
            end else begin
                m_ph = -1; m_idx = '0; m_fb = 1'b0;
            end
        end else begin
            m_ph++; m_fb = 1'b0; m_fd = 1'b0;
        end
        if (m_ph == FC) m_word = pal[m_idx];
        if (m_ph >= FC && ((m_ph - FC) % 2 == 0))
            m_mosi = m_word[15 - (m_ph - FC) / 2];

        check("pixel_index", pixel_index, m_idx);
        check("busy",        busy,        m_ph >= 0);
        check("cs_n",        oled_cs_n,   !(m_ph >= FC));
        check("sclk",        oled_sclk,   (m_ph >= FC) && ((m_ph - FC) % 2 == 1));
        check("mosi",        oled_mosi,   m_mosi);
        check("dc",          oled_dc,     m_dc);
        check("frame_begin", frame_begin, m_fb);
        check("frame_done",  frame_done,  m_fd);
        if (frame_begin && frame_done) n_wrap++;

        // Receiver: samples mosi on sclk rising while selected.
        if (!rst_s) begin
            dec_word = '0; dec_bits = 0; dec_len = 0;
        end else if (!oled_cs_n) begin
            dec_len++;
            if (oled_sclk && !prev_sclk) begin
                dec_word = {dec_word[14:0], oled_mosi};
                dec_bits++;
            end
        end else if (!prev_cs) begin
            check("word",   dec_word, m_word);
            check("bits",   dec_bits, 16);
            check("cs_len", dec_len,  32);
            dec_word = '0; dec_bits = 0; dec_len = 0;
        end
        prev_cs   = oled_cs_n;
        prev_sclk = oled_sclk;
        rst_s     = rst_n;
        en_s      = enable;
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk25);
            #2;
        end
    endtask

    initial begin
        bit found;
        rst_n  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 8192; i++) pal[i] = 16'hF800;
        cycles(3);
        rst_n = 1'b1;
        cycles(4 * PERIOD);

        // Identity colours across a full frame and its wrap.
        rst_n = 1'b0;
        for (int i = 0; i < PIX; i++) pal[i] = 16'(i);
        cycles(2);
        rst_n  = 1'b1;
        n_wrap = 0;
        cycles(PIX * PERIOD + 6 * PERIOD);
        check("wrap_seen", n_wrap != 0, 1'b1);

        // Random colours; drop enable at s=10 of pixel 57.
        rst_n = 1'b0;
        for (int i = 0; i < PIX; i++) pal[i] = 16'($urandom);
        cycles(2);
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3 * PIX * PERIOD && !found; i++) begin
            cycles(1);
            if (m_idx == 57 && m_ph == FC + 10) found = 1'b1;
        end
        check("wait_px57_s10", found, 1'b1);
        enable = 1'b0;
        cycles(40);
        check("idle_busy", busy, 1'b0);
        check("idle_pix",  pixel_index, 13'd0);
        enable = 1'b1;
        cycles(3 * PERIOD);

        // Reset at s=20.
        found = 1'b0;
        for (int i = 0; i < 4 * PERIOD && !found; i++) begin
            cycles(1);
            if (m_ph == FC + 20) found = 1'b1;
        end
        check("wait_s20", found, 1'b1);
        rst_n = 1'b0;
        cycles(1);
        check("rst_cs_n", oled_cs_n, 1'b1);
        check("rst_sclk", oled_sclk, 1'b0);
        check("rst_pix",  pixel_index, 13'd0);
        rst_n = 1'b1;
        cycles(3 * PERIOD);

        // Random enable toggling and occasional reset pulses.
        for (int i = 0; i < 12000; i++) begin
            if (enable ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 19) == 0))
                enable = ~enable;
            rst_n = ($urandom_range(0, 2999) != 0);
            cycles(1);
        end
        rst_n = 1'b1;
        cycles(2 * PERIOD);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
